// File: rtl/mmu_tlb_pkg.sv
// Shared types and constants for the 4-set x 2-way MMU TLB.
// Build option: TLB_DATA_RESET_EN (see mmu_tlb_way) also resets entry payloads.
package mmu_tlb_pkg;

    localparam int TAG_W   = 16;
    localparam int IDX_W   = 2;
    localparam int SETS    = 4;
    localparam int WAYS    = 2;
    localparam int TID_W   = 14;
    localparam int FLAGS_W = 14;
    localparam int PPN_W   = 18;
    localparam int VPN_W   = TAG_W + IDX_W;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [TID_W-1:0]   tid;
        logic [FLAGS_W-1:0] flags;
        logic [PPN_W-1:0]   ppn;
    } entry_t;

    function automatic logic entry_match(
        input logic             valid,
        input entry_t           ent,
        input logic [TAG_W-1:0] tag,
        input logic [TID_W-1:0] tid
    );
        return valid && (ent.tag == tag) && (ent.tid == tid);
    endfunction

endpackage

// File: rtl/mmu_tlb_way.sv
// One TLB way: 4 entries with valid bits, saturating age counters and tag/tid compare.
// With TLB_DATA_RESET_EN defined, reset also clears tag/tid/flags/ppn of every entry.
module mmu_tlb_way
    import mmu_tlb_pkg::*;
#(
    parameter int LRU_TIMING_N = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [IDX_W-1:0]        rd_idx,
    input  logic [TAG_W-1:0]        rd_tag,
    input  logic [TID_W-1:0]        rd_tid,
    output logic                    rd_match,
    output entry_t                  rd_entry,
    input  logic [IDX_W-1:0]        wr_idx,
    input  entry_t                  wr_entry,
    input  logic                    wr_en,
    output logic                    wr_match,
    output logic                    wr_valid,
    output logic [LRU_TIMING_N-1:0] wr_age,
    input  logic [SETS-1:0]         age_clr,
    input  logic [SETS-1:0]         age_inc
);

    localparam logic [LRU_TIMING_N-1:0] AGE_MAX = {LRU_TIMING_N{1'b1}};
    localparam logic [LRU_TIMING_N-1:0] AGE_ONE = {{(LRU_TIMING_N-1){1'b0}}, 1'b1};

    logic [SETS-1:0]         valid_r;
    logic [LRU_TIMING_N-1:0] age_r [SETS];
    entry_t                  data_r [SETS];

    assign rd_entry = data_r[rd_idx];
    assign rd_match = entry_match(valid_r[rd_idx], data_r[rd_idx], rd_tag, rd_tid);
    assign wr_valid = valid_r[wr_idx];
    assign wr_match = entry_match(valid_r[wr_idx], data_r[wr_idx], wr_entry.tag, wr_entry.tid);
    assign wr_age   = age_r[wr_idx];

    // Valid bits and ages: flush wipes everything, otherwise fill sets valid and ages update per set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            for (int s = 0; s < SETS; s++) age_r[s] <= '0;
        end else if (flush) begin
            valid_r <= '0;
            for (int s = 0; s < SETS; s++) age_r[s] <= '0;
        end else begin
            if (wr_en) valid_r[wr_idx] <= 1'b1;
            for (int s = 0; s < SETS; s++) begin
                if (age_clr[s]) begin
                    age_r[s] <= '0;
                end else if (age_inc[s] && (age_r[s] != AGE_MAX)) begin
                    age_r[s] <= age_r[s] + AGE_ONE;
                end
            end
        end
    end

`ifdef TLB_DATA_RESET_EN
    // Entry payload storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) data_r[s] <= '0;
        end else if (wr_en) begin
            data_r[wr_idx] <= wr_entry;
        end
    end
`else
    // Entry payload storage; invalid entries never hit, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) data_r[wr_idx] <= wr_entry;
    end
`endif

endmodule

// File: rtl/mmu_tlb.sv
// MMU TLB top: two ways, victim selection, age control and registered lookup outputs.
// Optional build macro TLB_DATA_RESET_EN is handled inside mmu_tlb_way.
module mmu_tlb
    import mmu_tlb_pkg::*;
#(
    parameter int LRU_TIMING_N = 10
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iREMOVE,
    input  logic               iRD_REQ,
    input  logic [VPN_W-1:0]   iRD_ADDR,
    input  logic [TID_W-1:0]   iRD_TID,
    output logic               oRD_VALID,
    output logic               oRD_HIT,
    output logic [FLAGS_W-1:0] oRD_FLAGS,
    output logic [PPN_W-1:0]   oRD_PHYS_ADDR,
    input  logic               iWR_REQ,
    input  logic [VPN_W-1:0]   iWR_ADDR,
    input  logic [TID_W-1:0]   iWR_TID,
    input  logic [FLAGS_W-1:0] iWR_FLAGS,
    input  logic [PPN_W-1:0]   iWR_PHYS_ADDR
);

    logic [IDX_W-1:0]        rd_idx_s;
    logic [TAG_W-1:0]        rd_tag_s;
    logic [IDX_W-1:0]        wr_idx_s;
    entry_t                  wr_entry_s;
    logic [WAYS-1:0]         rd_match_s;
    entry_t                  rd_entry_s [WAYS];
    logic [WAYS-1:0]         wr_match_s;
    logic [WAYS-1:0]         wr_valid_s;
    logic [LRU_TIMING_N-1:0] wr_age_s [WAYS];
    logic [WAYS-1:0]         wr_en_s;
    logic [SETS-1:0]         age_clr_s [WAYS];
    logic [SETS-1:0]         age_inc_s [WAYS];
    logic                    fill_s;
    logic                    wr_way_s;
    logic                    rd_hit_s;
    logic                    rd_way_s;
    logic                    rd_age_s;
    entry_t                  rd_data_s;

    logic                    rd_valid_r;
    logic                    rd_hit_r;
    logic [FLAGS_W-1:0]      rd_flags_r;
    logic [PPN_W-1:0]        rd_ppn_r;

    assign rd_idx_s         = iRD_ADDR[IDX_W-1:0];
    assign rd_tag_s         = iRD_ADDR[VPN_W-1:IDX_W];
    assign wr_idx_s         = iWR_ADDR[IDX_W-1:0];
    assign wr_entry_s.tag   = iWR_ADDR[VPN_W-1:IDX_W];
    assign wr_entry_s.tid   = iWR_TID;
    assign wr_entry_s.flags = iWR_FLAGS;
    assign wr_entry_s.ppn   = iWR_PHYS_ADDR;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        mmu_tlb_way #(.LRU_TIMING_N(LRU_TIMING_N)) u_way (
            .clk      (iCLOCK),
            .rst_n    (inRESET),
            .flush    (iREMOVE),
            .rd_idx   (rd_idx_s),
            .rd_tag   (rd_tag_s),
            .rd_tid   (iRD_TID),
            .rd_match (rd_match_s[w]),
            .rd_entry (rd_entry_s[w]),
            .wr_idx   (wr_idx_s),
            .wr_entry (wr_entry_s),
            .wr_en    (wr_en_s[w]),
            .wr_match (wr_match_s[w]),
            .wr_valid (wr_valid_s[w]),
            .wr_age   (wr_age_s[w]),
            .age_clr  (age_clr_s[w]),
            .age_inc  (age_inc_s[w])
        );
    end

    // Fill victim: matching way, then first invalid way, then the older way (ties to way 0).
    always_comb begin
        wr_way_s = 1'b0;
        if (wr_match_s[0]) begin
            wr_way_s = 1'b0;
        end else if (wr_match_s[1]) begin
            wr_way_s = 1'b1;
        end else if (!wr_valid_s[0]) begin
            wr_way_s = 1'b0;
        end else if (!wr_valid_s[1]) begin
            wr_way_s = 1'b1;
        end else if (wr_age_s[1] > wr_age_s[0]) begin
            wr_way_s = 1'b1;
        end else begin
            wr_way_s = 1'b0;
        end
    end

    assign fill_s    = iWR_REQ && !iREMOVE;
    assign rd_hit_s  = iRD_REQ && !iREMOVE && (|rd_match_s);
    assign rd_way_s  = !rd_match_s[0];
    assign rd_data_s = rd_entry_s[rd_way_s];
    // A read hit in the set being filled this cycle leaves ageing to the fill.
    assign rd_age_s  = rd_hit_s && !(fill_s && (wr_idx_s == rd_idx_s));

    // Per-way write enables and per-set age clear/increment requests.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            wr_en_s[w] = fill_s && (wr_way_s == 1'(w));
            for (int s = 0; s < SETS; s++) begin
                age_clr_s[w][s] = (fill_s && (wr_idx_s == IDX_W'(s)) && (wr_way_s == 1'(w)))
                               || (rd_age_s && (rd_idx_s == IDX_W'(s)) && (rd_way_s == 1'(w)));
                age_inc_s[w][s] = (fill_s && (wr_idx_s == IDX_W'(s)) && (wr_way_s != 1'(w)))
                               || (rd_age_s && (rd_idx_s == IDX_W'(s)) && (rd_way_s != 1'(w)));
            end
        end
    end

    // Registered lookup result; data holds when no lookup is sampled.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rd_valid_r <= 1'b0;
            rd_hit_r   <= 1'b0;
            rd_flags_r <= '0;
            rd_ppn_r   <= '0;
        end else begin
            rd_valid_r <= iRD_REQ;
            rd_hit_r   <= rd_hit_s;
            if (iRD_REQ) begin
                rd_flags_r <= rd_hit_s ? rd_data_s.flags : {FLAGS_W{1'b0}};
                rd_ppn_r   <= rd_hit_s ? rd_data_s.ppn   : {PPN_W{1'b0}};
            end
        end
    end

    assign oRD_VALID     = rd_valid_r;
    assign oRD_HIT       = rd_hit_r;
    assign oRD_FLAGS     = rd_flags_r;
    assign oRD_PHYS_ADDR = rd_ppn_r;

endmodule

// File: tb/tb_mmu_tlb.sv
// Scoreboard bench for mmu_tlb: lookups push expected results, a negedge monitor pops and compares.
module tb_mmu_tlb;

    typedef struct {
        string       name;
        logic        hit;
        logic [13:0] flags;
        logic [17:0] ppn;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rm;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic [13:0] rd_tid;
    logic        rd_valid;
    logic        rd_hit;
    logic [13:0] rd_flags;
    logic [17:0] rd_phys;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [13:0] wr_tid;
    logic [13:0] wr_flags;
    logic [17:0] wr_phys;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    mmu_tlb #(.LRU_TIMING_N(10)) dut (
        .iCLOCK        (clk),
        .inRESET       (rst_n),
        .iREMOVE       (rm),
        .iRD_REQ       (rd_req),
        .iRD_ADDR      (rd_addr),
        .iRD_TID       (rd_tid),
        .oRD_VALID     (rd_valid),
        .oRD_HIT       (rd_hit),
        .oRD_FLAGS     (rd_flags),
        .oRD_PHYS_ADDR (rd_phys),
        .iWR_REQ       (wr_req),
        .iWR_ADDR      (wr_addr),
        .iWR_TID       (wr_tid),
        .iWR_FLAGS     (wr_flags),
        .iWR_PHYS_ADDR (wr_phys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Monitor: every valid result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_hit"},   {31'd0, rd_hit},   {31'd0, mon_e.hit});
                check({mon_e.name, "_flags"}, {18'd0, rd_flags}, {18'd0, mon_e.flags});
                check({mon_e.name, "_phys"},  {14'd0, rd_phys},  {14'd0, mon_e.ppn});
            end
        end
    end

    task automatic tlb_op(input logic rd, input logic [17:0] ra, input logic [13:0] rt,
                          input logic wr, input logic [17:0] wa, input logic [13:0] wt,
                          input logic [13:0] wf, input logic [17:0] wp, input logic r,
                          input logic eh, input logic [13:0] ef, input logic [17:0] ep,
                          input string name);
        exp_t e;
        rd_req = rd; rd_addr = ra; rd_tid = rt;
        wr_req = wr; wr_addr = wa; wr_tid = wt; wr_flags = wf; wr_phys = wp;
        rm = r;
        if (rd) begin
            e.name = name; e.hit = eh; e.flags = ef; e.ppn = ep;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        rd_req = 1'b0; wr_req = 1'b0; rm = 1'b0;
    endtask

    task automatic do_read(input logic [17:0] a, input logic [13:0] t, input logic eh,
                           input logic [13:0] ef, input logic [17:0] ep, input string name);
        tlb_op(1'b1, a, t, 1'b0, 18'd0, 14'd0, 14'd0, 18'd0, 1'b0, eh, ef, ep, name);
    endtask

    task automatic do_fill(input logic [17:0] a, input logic [13:0] t,
                           input logic [13:0] f, input logic [17:0] p);
        tlb_op(1'b0, 18'd0, 14'd0, 1'b1, a, t, f, p, 1'b0, 1'b0, 14'd0, 18'd0, "");
    endtask

    task automatic do_idle();
        tlb_op(1'b0, 18'd0, 14'd0, 1'b0, 18'd0, 14'd0, 14'd0, 18'd0, 1'b0, 1'b0, 14'd0, 18'd0, "");
    endtask

    initial begin
        rst_n = 1'b0; rm = 1'b0;
        rd_req = 1'b0; rd_addr = 18'd0; rd_tid = 14'd0;
        wr_req = 1'b0; wr_addr = 18'd0; wr_tid = 14'd0; wr_flags = 14'd0; wr_phys = 18'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_hit",   {31'd0, rd_hit},   32'd0);
        check("rst_flags", {18'd0, rd_flags}, 32'd0);
        check("rst_phys",  {14'd0, rd_phys},  32'd0);
        rst_n = 1'b1;
        do_idle();

        // Cold miss, then the valid pulse must drop.
        do_read(18'h00005, 14'd1, 1'b0, 14'h0000, 18'h00000, "cold_miss");
        do_idle();
        check("valid_pulse_end", {31'd0, rd_valid}, 32'd0);

        // Basic fill and TID-qualified hit.
        do_fill(18'h00005, 14'd1, 14'h0003, 18'h2ABCD);
        do_read(18'h00005, 14'd1, 1'b1, 14'h0003, 18'h2ABCD, "fill_hit");
        do_idle();
        check("idle_hit_low",   {31'd0, rd_hit},  32'd0);
        check("idle_phys_hold", {14'd0, rd_phys}, 32'h0002ABCD);
        do_read(18'h00005, 14'd2, 1'b0, 14'h0000, 18'h00000, "tid_miss");

        // LRU eviction in set 1.
        do_fill(18'h00005, 14'd1, 14'h0011, 18'h00001);
        do_fill(18'h00009, 14'd1, 14'h0022, 18'h00002);
        do_read(18'h00005, 14'd1, 1'b1, 14'h0011, 18'h00001, "lru_touch");
        do_fill(18'h0000D, 14'd1, 14'h0033, 18'h00003);
        do_read(18'h00005, 14'd1, 1'b1, 14'h0011, 18'h00001, "lru_keep");
        do_read(18'h0000D, 14'd1, 1'b1, 14'h0033, 18'h00003, "lru_new");
        do_read(18'h00009, 14'd1, 1'b0, 14'h0000, 18'h00000, "lru_evicted");

        // Refill of an existing VPN/TID updates in place.
        do_fill(18'h0000D, 14'd1, 14'h3FFF, 18'h3FFFF);
        do_read(18'h0000D, 14'd1, 1'b1, 14'h3FFF, 18'h3FFFF, "refill_new");
        do_read(18'h00005, 14'd1, 1'b1, 14'h0011, 18'h00001, "refill_other");

        // Flush, flush-with-write, flush-with-read.
        tlb_op(1'b0, 18'd0, 14'd0, 1'b0, 18'd0, 14'd0, 14'd0, 18'd0, 1'b1, 1'b0, 14'd0, 18'd0, "");
        do_read(18'h00005, 14'd1, 1'b0, 14'h0000, 18'h00000, "flush_miss_a");
        do_read(18'h0000D, 14'd1, 1'b0, 14'h0000, 18'h00000, "flush_miss_b");
        tlb_op(1'b0, 18'd0, 14'd0, 1'b1, 18'h00020, 14'd3, 14'h0007, 18'h00777, 1'b1,
               1'b0, 14'd0, 18'd0, "");
        do_read(18'h00020, 14'd3, 1'b0, 14'h0000, 18'h00000, "flush_drops_wr");
        do_fill(18'h00005, 14'd1, 14'h0011, 18'h00001);
        tlb_op(1'b1, 18'h00005, 14'd1, 1'b0, 18'd0, 14'd0, 14'd0, 18'd0, 1'b1,
               1'b0, 14'h0000, 18'h00000, "flush_rd_miss");
        do_read(18'h00005, 14'd1, 1'b0, 14'h0000, 18'h00000, "flush_rd_after");

        // Same-cycle fill and read: no bypass.
        tlb_op(1'b1, 18'h00010, 14'd0, 1'b1, 18'h00010, 14'd0, 14'h0155, 18'h15555, 1'b0,
               1'b0, 14'h0000, 18'h00000, "same_cycle_miss");
        do_read(18'h00010, 14'd0, 1'b1, 14'h0155, 18'h15555, "same_cycle_next");

        // Asynchronous reset cancels a pending result and invalidates entries.
        rd_req = 1'b1; rd_addr = 18'h00010; rd_tid = 14'd0;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        check("mid_valid_before", {31'd0, rd_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_valid_cancel", {31'd0, rd_valid}, 32'd0);
        check("mid_hit_cancel",   {31'd0, rd_hit},   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_idle();
        do_read(18'h00010, 14'd0, 1'b0, 14'h0000, 18'h00000, "post_reset_miss");

        repeat (3) do_idle();
        check("sb_drain", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
